shift_div_seq: RTL and testbench

Parametrised multi-cycle shifter that divides or multiplies by a power of two, with a start/busy/done handshake. It shifts by up to STEP bits per enabled cycle and supports four modes: logical right, arithmetic right (floor), signed divide (truncate toward zero), and logical left with overflow detect. It succeeds the fixed 16-bit shift-by-4 datapath stage, generalising width, shift amount and mode. It sits in the divider datapath wherever the divisor is a power of two.

---
 rtl/shift_div_seq.sv | 121 ++++++++++++
 tb/tb_shift_div_seq.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/shift_div_seq.sv
// Multi-cycle power-of-two shifter: logical/arithmetic right, signed divide (trunc),
// logical left with overflow detect. Shifts up to STEP bits per enabled cycle.
module shift_div_seq #(
    parameter int WIDTH = 16,
    parameter int STEP  = 4,
    parameter int AMT_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             en,
    input  logic [WIDTH-1:0] data,
    input  logic [AMT_W-1:0] amt,
    input  logic [1:0]       mode,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] q,
    output logic             ovf
);

    typedef enum logic {IDLE, RUN} state_t;
    typedef enum logic [1:0] {
        M_LSR = 2'b00,
        M_ASR = 2'b01,
        M_DIV = 2'b10,
        M_LSL = 2'b11
    } mode_t;

    localparam logic [AMT_W-1:0] LP_WIDTH = AMT_W'(WIDTH);
    localparam logic [AMT_W-1:0] LP_STEP  = AMT_W'(STEP);
    localparam logic [WIDTH:0]   LP_ONE   = {{WIDTH{1'b0}}, 1'b1};

    state_t           r_state;
    mode_t            r_mode;
    logic [WIDTH:0]   r_acc;
    logic [AMT_W-1:0] r_rem;
    logic             r_flag;

    logic [AMT_W-1:0]    w_amt_c;
    logic [WIDTH:0]      w_ext;
    logic [WIDTH:0]      w_bias;
    logic [WIDTH:0]      w_load;
    logic [AMT_W-1:0]    w_k;
    logic [AMT_W-1:0]    w_rem_nxt;
    logic [WIDTH:0]      w_lsr;
    logic signed [WIDTH:0] w_asr;
    logic [WIDTH:0]      w_shl;
    logic [WIDTH-1:0]    w_lost;
    logic                w_lost_any;
    logic [WIDTH:0]      w_acc_nxt;
    logic                w_flag_nxt;

    // Load path: sign-extend for signed modes; negative divide gets a 2^amt-1 bias
    // so the later floor shift truncates toward zero.
    always_comb begin
        w_amt_c = (amt > LP_WIDTH) ? LP_WIDTH : amt;
        w_ext   = (mode[0] ^ mode[1]) ? {data[WIDTH-1], data} : {1'b0, data};
        w_bias  = '0;
        if (mode == M_DIV && data[WIDTH-1]) begin
            w_bias = (LP_ONE << w_amt_c) - LP_ONE;
        end
        w_load = w_ext + w_bias;
    end

    always_comb begin
        w_k       = (r_rem < LP_STEP) ? r_rem : LP_STEP;
        w_rem_nxt = r_rem - w_k;
        w_lsr     = r_acc >> w_k;
        w_asr     = $signed(r_acc) >>> w_k;
        w_shl     = {1'b0, r_acc[WIDTH-1:0] << w_k};
        w_lost    = '0;
        if (w_k != '0) begin
            w_lost = r_acc[WIDTH-1:0] >> (LP_WIDTH - w_k);
        end
        w_lost_any = |w_lost;
        w_flag_nxt = r_flag | w_lost_any;
        case (r_mode)
            M_LSR:   w_acc_nxt = w_lsr;
            M_LSL:   w_acc_nxt = w_shl;
            default: w_acc_nxt = w_asr;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_mode  <= M_LSR;
            r_acc   <= '0;
            r_rem   <= '0;
            r_flag  <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            q       <= '0;
            ovf     <= 1'b0;
        end else begin
            done <= 1'b0;
            if (r_state == IDLE) begin
                if (start) begin
                    r_acc   <= w_load;
                    r_rem   <= w_amt_c;
                    r_mode  <= mode_t'(mode);
                    r_flag  <= 1'b0;
                    busy    <= 1'b1;
                    r_state <= RUN;
                end
            end else if (en) begin
                r_acc  <= w_acc_nxt;
                r_rem  <= w_rem_nxt;
                r_flag <= w_flag_nxt;
                if (w_rem_nxt == '0) begin
                    q       <= w_acc_nxt[WIDTH-1:0];
                    ovf     <= (r_mode == M_LSL) ? w_flag_nxt : 1'b0;
                    done    <= 1'b1;
                    busy    <= 1'b0;
                    r_state <= IDLE;
                end
            end
        end
    end

endmodule

// File: tb/tb_shift_div_seq.sv
// Scoreboard bench for shift_div_seq: driver pushes model results, negedge monitor
// pops and compares result, overflow and start-to-done latency on every done.
module tb_shift_div_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        start = 1'b0;
    logic        en = 1'b0;
    logic [15:0] data = '0;
    logic [4:0]  amt = '0;
    logic [1:0]  mode = '0;
    logic        busy, done, ovf;
    logic [15:0] q;

    shift_div_seq #(.WIDTH(16), .STEP(4), .AMT_W(5)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .en(en), .data(data),
        .amt(amt), .mode(mode), .busy(busy), .done(done), .q(q), .ovf(ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] q;
        logic        ovf;
        int          base_lat;
        int          acc_edge;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   n_vec = 0;
    int   n_err = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic flag_fail(input string name);
        n_vec++;
        n_err++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    // Reference: plain integer arithmetic on the clamped amount.
    function automatic exp_t model(input logic [15:0] d, input logic [4:0] a, input logic [1:0] m);
        exp_t r;
        int ac;
        int sd;
        longint unsigned p;
        ac = (a > 5'd16) ? 16 : int'(a);
        sd = int'($signed(d));
        r.ovf = 1'b0;
        case (m)
            2'b00: r.q = 16'(int'(d) >> ac);
            2'b01: r.q = 16'(sd >>> ac);
            2'b10: r.q = 16'(sd / (1 << ac));
            default: begin
                p = longint'(d) << ac;
                r.q = p[15:0];
                r.ovf = ((p >> 16) != 0);
            end
        endcase
        r.base_lat = (ac == 0) ? 1 : (ac + 3) / 4;
        r.acc_edge = 0;
        r.lat = 0;
        return r;
    endfunction

    always @(negedge clk) begin
        if (rst_n && done) begin
            if (sb.size() == 0) begin
                flag_fail("spurious_done");
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("q", 32'(q), 32'(e.q));
                check("ovf", 32'(ovf), 32'(e.ovf));
                check("latency", 32'(cyc - e.acc_edge), 32'(e.lat));
                check("busy_at_done", 32'(busy), 32'd0);
            end
        end
    end

    task automatic wait_idle();
        int w = 0;
        while (busy && w < 200) begin
            @(negedge clk);
            w++;
        end
        if (busy) flag_fail("busy_timeout");
    endtask

    task automatic wait_done();
        int w = 0;
        while (!done && w < 200) begin
            @(negedge clk);
            w++;
        end
        if (!done) flag_fail("done_timeout");
    endtask

    // Called at a negedge; stalls en on edges stall_at+1 .. stall_at+stall_len after accept.
    task automatic issue(input logic [15:0] d, input logic [4:0] a, input logic [1:0] m,
                         input int stall_at, input int stall_len, input bit pulse);
        exp_t e;
        int k;
        wait_idle();
        data  = d;
        amt   = a;
        mode  = m;
        start = 1'b1;
        en    = 1'($urandom_range(0, 1));
        e = model(d, a, m);
        e.acc_edge = cyc + 1;
        e.lat = e.base_lat + ((stall_at < e.base_lat) ? stall_len : 0);
        sb.push_back(e);
        @(negedge clk);
        start = 1'b0;
        k = 1;
        while (!done && k < 200) begin
            en    = !(k > stall_at && k <= stall_at + stall_len);
            start = pulse && (k == 2);
            data  = 16'($urandom);
            @(negedge clk);
            k++;
        end
        en    = 1'b1;
        start = 1'b0;
        if (!done) flag_fail("op_timeout");
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e1, e2;
        int c0;
        #3 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_q", 32'(q), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_ovf", 32'(ovf), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed cases
        issue(16'hAAAA, 5'd4, 2'b00, 99, 0, 1'b0);
        issue(16'hF0F0, 5'd5, 2'b01, 99, 0, 1'b0);
        issue(16'hF0F0, 5'd5, 2'b10, 99, 0, 1'b0);
        issue(16'h0F0F, 5'd6, 2'b11, 99, 0, 1'b0);
        issue(16'h0001, 5'd15, 2'b11, 99, 0, 1'b0);
        issue(16'h1234, 5'd12, 2'b00, 1, 3, 1'b1);
        repeat (8) @(negedge clk);
        check("no_extra_busy", 32'(busy), 32'd0);
        check("q_held", 32'(q), 32'h0001);
        issue(16'h5A5A, 5'd0, 2'b00, 99, 0, 1'b0);
        issue(16'hFFFF, 5'd16, 2'b11, 99, 0, 1'b0);
        issue(16'h8001, 5'd16, 2'b10, 99, 0, 1'b0);
        issue(16'h0000, 5'd20, 2'b11, 99, 0, 1'b0);

        // start held high through done: second op accepted on the edge after done
        wait_idle();
        c0 = cyc;
        data = 16'h8000; amt = 5'd31; mode = 2'b01; start = 1'b1; en = 1'b1;
        e1 = model(16'h8000, 5'd31, 2'b01);
        e1.acc_edge = c0 + 1;
        e1.lat = e1.base_lat;
        sb.push_back(e1);
        @(negedge clk);
        data = 16'h5A5A; amt = 5'd0; mode = 2'b00;
        e2 = model(16'h5A5A, 5'd0, 2'b00);
        e2.acc_edge = c0 + 1 + e1.base_lat + 1;
        e2.lat = e2.base_lat;
        sb.push_back(e2);
        wait_done();
        @(negedge clk);
        start = 1'b0;
        wait_done();
        @(negedge clk);

        // Asynchronous reset mid-run after a result with q and ovf both nonzero
        issue(16'h0F0F, 5'd6, 2'b11, 99, 0, 1'b0);
        @(negedge clk);
        data = 16'hFFFF; amt = 5'd16; mode = 2'b11; start = 1'b1; en = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_busy", 32'(busy), 32'd0);
        check("async_rst_done", 32'(done), 32'd0);
        check("async_rst_q", 32'(q), 32'd0);
        check("async_rst_ovf", 32'(ovf), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        check("post_rst_busy", 32'(busy), 32'd0);
        issue(16'hC000, 5'd3, 2'b01, 99, 0, 1'b0);

        // Randomised operations with stalls and ignored mid-run starts
        for (int i = 0; i < 300; i++) begin
            logic [4:0] a;
            if ($urandom_range(0, 3) == 0) a = 5'($urandom_range(17, 31));
            else a = 5'($urandom_range(0, 16));
            issue(16'($urandom), a, 2'($urandom_range(0, 3)),
                  $urandom_range(0, 5), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 3) == 0) @(negedge clk);
        end

        repeat (5) @(negedge clk);
        check("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
